// File: rtl/instruction_fetch_unit.sv
// Per-core fetch stage: owns the fetch PC, issues one-word reads to a 1-cycle ROM port
// and buffers returned words with their PC in a small FIFO for decode.
module instruction_fetch_unit #(
  parameter int                    ADDR_WIDTH = 16,
  parameter int                    DATA_WIDTH = 16,
  parameter int                    FIFO_DEPTH = 2,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0
) (
  input  logic                  clk_i,
  input  logic                  rst_n_i,
  input  logic                  rom_ready_i,
  output logic                  rom_en_o,
  output logic [ADDR_WIDTH-1:0] rom_addr_o,
  input  logic [DATA_WIDTH-1:0] rom_data_i,
  input  logic                  rom_valid_i,
  input  logic                  redirect_valid_i,
  input  logic [ADDR_WIDTH-1:0] redirect_pc_i,
  input  logic                  halt_i,
  output logic                  fetch_valid_o,
  output logic [DATA_WIDTH-1:0] fetch_instr_o,
  output logic [ADDR_WIDTH-1:0] fetch_pc_o,
  input  logic                  fetch_ready_i,
  output logic                  busy_o,
  output logic [31:0]           fetch_count_o,
  output logic [15:0]           retry_count_o
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int OCC_W = PTR_W + 1;

  typedef enum logic [1:0] {WAIT_ROM, RUN, HALTED} state_e;

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] pc_q, pc_d, inflightPc_q, inflightPc_d;
  logic                  inflight_q, inflight_d, discard_q, discard_d;
  logic [OCC_W-1:0]      occ_q, occ_d;
  logic [PTR_W-1:0]      rdPtr_q, rdPtr_d, wrPtr_q, wrPtr_d;
  logic [ADDR_WIDTH-1:0] memPc_q    [FIFO_DEPTH];
  logic [DATA_WIDTH-1:0] memInstr_q [FIFO_DEPTH];
  logic [31:0]           fetchCount_q, fetchCount_d;
  logic [15:0]           retryCount_q, retryCount_d;

  logic headValid, pop, popEff, respLive, push, retry, issue;
  int   pending;

  always_comb begin
    headValid = rst_n_i && (occ_q != '0);
    pop       = headValid && fetch_ready_i;
    popEff    = pop && !redirect_valid_i;
    respLive  = rst_n_i && inflight_q && !discard_q && !redirect_valid_i;
    push      = respLive && rom_valid_i;
    retry     = respLive && !rom_valid_i;
    pending   = int'(occ_q) + int'(inflight_q) - int'(pop);
    issue     = rst_n_i && (state_q == RUN) && rom_ready_i && !halt_i &&
                !redirect_valid_i && (pending < FIFO_DEPTH);

    rom_en_o      = issue;
    rom_addr_o    = rst_n_i ? pc_q : RESET_PC;
    fetch_valid_o = headValid;
    fetch_instr_o = headValid ? memInstr_q[rdPtr_q] : '0;
    fetch_pc_o    = headValid ? memPc_q[rdPtr_q] : '0;
    busy_o        = rst_n_i && (inflight_q || (occ_q != '0));
    fetch_count_o = fetchCount_q;
    retry_count_o = retryCount_q;
  end

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    inflight_d   = issue;
    inflightPc_d = issue ? pc_q : inflightPc_q;
    // A request issued while a retry rewinds the PC is out of order, so its reply is dropped.
    discard_d    = issue && retry;
    occ_d        = occ_q;
    rdPtr_d      = rdPtr_q;
    wrPtr_d      = wrPtr_q;
    fetchCount_d = popEff ? fetchCount_q + 32'd1 : fetchCount_q;
    retryCount_d = (retry && (retryCount_q != 16'hFFFF)) ? retryCount_q + 16'd1 : retryCount_q;

    if (!rom_ready_i) begin
      state_d = WAIT_ROM;
    end else begin
      case (state_q)
        WAIT_ROM: state_d = RUN;
        RUN:      if (halt_i) state_d = HALTED;
        HALTED:   if (!halt_i) state_d = RUN;
        default:  state_d = WAIT_ROM;
      endcase
    end

    if (redirect_valid_i) begin
      pc_d = redirect_pc_i;
    end else if (retry) begin
      pc_d = inflightPc_q;
    end else if (issue) begin
      pc_d = pc_q + ADDR_WIDTH'(1);
    end

    if (redirect_valid_i) begin
      occ_d   = '0;
      rdPtr_d = '0;
      wrPtr_d = '0;
    end else begin
      if (push)   wrPtr_d = wrPtr_q + PTR_W'(1);
      if (popEff) rdPtr_d = rdPtr_q + PTR_W'(1);
      occ_d = occ_q + OCC_W'(push) - OCC_W'(popEff);
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state_q      <= WAIT_ROM;
      pc_q         <= RESET_PC;
      inflight_q   <= 1'b0;
      inflightPc_q <= RESET_PC;
      discard_q    <= 1'b0;
      occ_q        <= '0;
      rdPtr_q      <= '0;
      wrPtr_q      <= '0;
      fetchCount_q <= '0;
      retryCount_q <= '0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      inflight_q   <= inflight_d;
      inflightPc_q <= inflightPc_d;
      discard_q    <= discard_d;
      occ_q        <= occ_d;
      rdPtr_q      <= rdPtr_d;
      wrPtr_q      <= wrPtr_d;
      fetchCount_q <= fetchCount_d;
      retryCount_q <= retryCount_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push) begin
      memPc_q[wrPtr_q]    <= inflightPc_q;
      memInstr_q[wrPtr_q] <= rom_data_i;
    end
  end

  pushNotFull: assert property (@(posedge clk_i) disable iff (!rst_n_i)
    !(push && !popEff && (occ_q == OCC_W'(FIFO_DEPTH))));

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Directed bench for instruction_fetch_unit: a behavioural ROM answers reads and
// scoreboard monitors compare every word handed to decode against queued expectations.
module tb_instruction_fetch_unit;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rstN, romReady, redirectValid, halt, fetchReady;
  logic [15:0] redirectPc;
  logic        romEn, fetchValid, busy;
  logic [15:0] romAddr, fetchInstr, fetchPc, retryCount;
  logic [31:0] fetchCount;
  logic        romValid = 1'b0;
  logic [15:0] romData  = '0;

  logic        romEn2, fetchValid2, busy2;
  logic [15:0] romAddr2, fetchInstr2, fetchPc2, retryCount2;
  logic [31:0] fetchCount2;
  logic        romValid2 = 1'b0;
  logic [15:0] romData2  = '0;

  logic        dropEn;
  logic [15:0] dropAddr;
  logic        dropped = 1'b0;

  int          checks = 0;
  int          failures = 0;
  logic [31:0] expQ[$];
  logic [31:0] exp2Q[$];

  instruction_fetch_unit dut (
    .clk_i(clk), .rst_n_i(rstN), .rom_ready_i(romReady), .rom_en_o(romEn),
    .rom_addr_o(romAddr), .rom_data_i(romData), .rom_valid_i(romValid),
    .redirect_valid_i(redirectValid), .redirect_pc_i(redirectPc), .halt_i(halt),
    .fetch_valid_o(fetchValid), .fetch_instr_o(fetchInstr), .fetch_pc_o(fetchPc),
    .fetch_ready_i(fetchReady), .busy_o(busy), .fetch_count_o(fetchCount),
    .retry_count_o(retryCount)
  );

  instruction_fetch_unit #(.RESET_PC(16'hFFFE)) dut2 (
    .clk_i(clk), .rst_n_i(rstN), .rom_ready_i(romReady), .rom_en_o(romEn2),
    .rom_addr_o(romAddr2), .rom_data_i(romData2), .rom_valid_i(romValid2),
    .redirect_valid_i(1'b0), .redirect_pc_i(16'h0000), .halt_i(1'b0),
    .fetch_valid_o(fetchValid2), .fetch_instr_o(fetchInstr2), .fetch_pc_o(fetchPc2),
    .fetch_ready_i(1'b1), .busy_o(busy2), .fetch_count_o(fetchCount2),
    .retry_count_o(retryCount2)
  );

  function automatic logic [15:0] romWord(input logic [15:0] addr);
    case (addr)
      16'h0000: romWord = 16'h1100;
      16'h0001: romWord = 16'h1201;
      16'h0002: romWord = 16'h0112;
      16'h0003: romWord = 16'h91FD;
      16'h0004: romWord = 16'hE000;
      default:  romWord = addr ^ 16'h5A5A;
    endcase
  endfunction

  // ROM with fixed one-cycle latency; can withhold rom_valid once for dropAddr.
  always @(posedge clk) begin
    if (romEn && dropEn && !dropped && romAddr == dropAddr) begin
      romValid <= 1'b0;
      dropped  <= 1'b1;
    end else begin
      romValid <= romEn;
    end
    romData   <= romWord(romAddr);
    romValid2 <= romEn2;
    romData2  <= romWord(romAddr2);
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
    end
  endtask

  always @(negedge clk) begin
    if (rstN && fetchValid && fetchReady && !redirectValid) begin
      if (expQ.size() == 0) begin
        checks++;
        failures++;
        $display("[TB] FAIL sb_unexpected: got pc=%h instr=%h expected no delivery", fetchPc, fetchInstr);
      end else begin
        checkOutput("sb_fetch", {fetchPc, fetchInstr}, expQ.pop_front());
      end
    end
    if (rstN && fetchValid2 && exp2Q.size() != 0)
      checkOutput("sb_wrap", {fetchPc2, fetchInstr2}, exp2Q.pop_front());
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic rst, input logic rr, input logic fr,
                               input logic hl, input logic rv, input logic [15:0] rpc);
    rstN = rst; romReady = rr; fetchReady = fr; halt = hl;
    redirectValid = rv; redirectPc = rpc;
  endtask

  task automatic resetDut(input logic fr);
    applyStimulus(1'b0, 1'b0, fr, 1'b0, 1'b0, 16'h0000);
    tick(2);
    applyStimulus(1'b1, 1'b1, fr, 1'b0, 1'b0, 16'h0000);
  endtask

  task automatic waitCount(input logic [31:0] target, input int limit);
    int n = 0;
    while (fetchCount !== target && n < limit) begin
      tick(1);
      n++;
    end
    checkOutput("fetch_count_reached", fetchCount, target);
  endtask

  task automatic checkReset();
    checkOutput("rst_rom_en", romEn, 0);
    checkOutput("rst_rom_addr", romAddr, 32'h0000);
    checkOutput("rst_fetch_valid", fetchValid, 0);
    checkOutput("rst_fetch_instr", fetchInstr, 0);
    checkOutput("rst_fetch_pc", fetchPc, 0);
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_fetch_count", fetchCount, 0);
    checkOutput("rst_retry_count", retryCount, 0);
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    dropEn = 1'b0;
    dropAddr = 16'h0002;
    exp2Q = '{32'hFFFE_A5A4, 32'hFFFF_A5A5, 32'h0000_1100, 32'h0001_1201};
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0000);
    tick(2);
    @(negedge clk);
    checkReset();
    tick(1);

    // Streaming from reset with decode always ready.
    expQ = '{32'h0000_1100, 32'h0001_1201, 32'h0002_0112, 32'h0003_91FD, 32'h0004_E000};
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 16'h0000);
    @(negedge clk);
    checkOutput("a_wait_rom_no_issue", romEn, 0);
    tick(1);
    @(negedge clk);
    checkOutput("a_first_issue", romEn, 1);
    checkOutput("a_first_addr", romAddr, 32'h0000);
    checkOutput("a_valid_n1", fetchValid, 0);
    tick(1);
    @(negedge clk);
    checkOutput("a_valid_n1b", fetchValid, 0);
    checkOutput("a_second_addr", romAddr, 32'h0001);
    tick(1);
    @(negedge clk);
    checkOutput("a_valid_n2", fetchValid, 1);
    waitCount(32'd5, 20);
    fetchReady = 1'b0;
    checkOutput("a_sb_drained", 32'(expQ.size()), 0);

    // Backpressure, then a redirect with an entry buffered and a request inflight.
    resetDut(1'b0);
    expQ = '{32'h0000_1100, 32'h0001_1201, 32'h0003_91FD, 32'h0004_E000};
    tick(6);
    @(negedge clk);
    checkOutput("b_hold_valid", fetchValid, 1);
    checkOutput("b_hold_pc", fetchPc, 32'h0000);
    checkOutput("b_hold_instr", fetchInstr, 32'h1100);
    checkOutput("b_full_no_issue", romEn, 0);
    checkOutput("b_busy", busy, 1);
    tick(1);
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 16'h0000);
    @(negedge clk);
    checkOutput("b_release_issue", romEn, 1);
    checkOutput("b_release_addr", romAddr, 32'h0002);
    tick(2);
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 16'h0003);
    @(negedge clk);
    checkOutput("b_redirect_no_issue", romEn, 0);
    checkOutput("b_pre_flush_pc", fetchPc, 32'h0002);
    tick(1);
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 16'h0000);
    @(negedge clk);
    checkOutput("b_flushed_valid", fetchValid, 0);
    checkOutput("b_pop_not_counted", fetchCount, 32'd2);
    checkOutput("b_target_issue", romEn, 1);
    checkOutput("b_target_addr", romAddr, 32'h0003);
    waitCount(32'd4, 20);
    fetchReady = 1'b0;
    checkOutput("b_sb_drained", 32'(expQ.size()), 0);

    // One missing ROM response forces an in-order retry of pc 0002.
    resetDut(1'b1);
    dropEn = 1'b1;
    expQ = '{32'h0000_1100, 32'h0001_1201, 32'h0002_0112, 32'h0003_91FD};
    tick(5);
    @(negedge clk);
    checkOutput("e_refetch_en", romEn, 1);
    checkOutput("e_refetch_addr", romAddr, 32'h0002);
    waitCount(32'd4, 30);
    fetchReady = 1'b0;
    dropEn = 1'b0;
    checkOutput("e_retry_count", retryCount, 32'd1);
    checkOutput("e_sb_drained", 32'(expQ.size()), 0);

    // Halt mid-stream, resume, then reset mid-stream.
    resetDut(1'b1);
    expQ = '{32'h0000_1100, 32'h0001_1201, 32'h0002_0112, 32'h0003_91FD};
    tick(5);
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 16'h0000);
    @(negedge clk);
    checkOutput("f_halt_no_issue", romEn, 0);
    tick(3);
    @(negedge clk);
    checkOutput("f_halt_count", fetchCount, 32'd4);
    checkOutput("f_halt_valid", fetchValid, 0);
    checkOutput("f_halt_busy", busy, 0);
    tick(1);
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 16'h0000);
    @(negedge clk);
    checkOutput("f_still_halted", romEn, 0);
    checkOutput("f_pc_held", romAddr, 32'h0004);
    tick(1);
    @(negedge clk);
    checkOutput("f_resume_en", romEn, 1);
    checkOutput("f_resume_addr", romAddr, 32'h0004);
    tick(1);
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 16'h0000);
    @(negedge clk);
    checkOutput("f_in_reset_en", romEn, 0);
    checkOutput("f_in_reset_busy", busy, 0);
    tick(1);
    expQ = '{32'h0000_1100};
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 16'h0000);
    @(negedge clk);
    checkReset();
    waitCount(32'd1, 20);
    fetchReady = 1'b0;
    checkOutput("f_sb_drained", 32'(expQ.size()), 0);
    checkOutput("wrap_sb_drained", 32'(exp2Q.size()), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
